// File: rtl/imem_cache_if.sv
// Line-fill memory bus between imem_cache (master) and backing memory (slave).
// One word per MEM_ACK; MEM_ADDR is word aligned and held while waiting for the ack.
interface imem_cache_if;
  logic        MEM_REQ;
  logic [63:0] MEM_ADDR;
  logic        MEM_ACK;
  logic [31:0] MEM_RDATA;

  modport master (output MEM_REQ, MEM_ADDR, input  MEM_ACK, MEM_RDATA);
  modport slave  (input  MEM_REQ, MEM_ADDR, output MEM_ACK, MEM_RDATA);
endinterface

// File: rtl/imem_cache.sv
// Direct-mapped instruction cache: 16 lines x 4 words, zero-latency hit, blocking line fill.
// Optional perf counters (HIT_CNT / MISS_CNT) are built only when ICACHE_PERF_CNT_EN is defined.
module imem_cache (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [63:0]         PC,
  output logic                icache_r,
  output logic [31:0]         instruction,
  imem_cache_if.master        mem,
  output logic [31:0]         HIT_CNT,
  output logic [31:0]         MISS_CNT
);
  localparam int LINES = 16;
  localparam int WORDS = 4;

  typedef enum logic {IDLE, FILL} state_t;

  state_t                   state, state_nxt;
  logic [LINES-1:0]         valid;
  logic [55:0]              tag_q  [LINES];
  logic [WORDS-1:0][31:0]   data_q [LINES];
  logic [59:0]              base_q;   // PC[63:4] of the line being filled
  logic [1:0]               k_q;

  logic [55:0] pc_tag;
  logic [3:0]  pc_idx, fill_idx;
  logic [1:0]  pc_word;
  logic        in_range, hit, start_fill, fill_ack;
  logic        unused_pc_lsb;

  assign pc_tag        = PC[63:8];
  assign pc_idx        = PC[7:4];
  assign pc_word       = PC[3:2];
  assign in_range      = (PC[63:32] == 32'd0);
  assign fill_idx      = base_q[3:0];
  assign unused_pc_lsb = ^PC[1:0];
  assign fill_ack      = (state == FILL) && mem.MEM_ACK;

  assign hit = (state == IDLE) && !RESET && in_range && valid[pc_idx] &&
               (tag_q[pc_idx] == pc_tag);

  always_comb begin
    state_nxt    = state;
    start_fill   = 1'b0;
    mem.MEM_REQ  = 1'b0;
    mem.MEM_ADDR = 64'd0;
    icache_r     = hit;
    instruction  = hit ? data_q[pc_idx][pc_word] : 32'd0;
    case (state)
      IDLE: begin
        if (in_range && !hit) begin
          start_fill = 1'b1;
          state_nxt  = FILL;
        end
      end
      FILL: begin
        mem.MEM_REQ  = 1'b1;
        // line base has zero low nibble, so concatenation is base + 4k
        mem.MEM_ADDR = {base_q, k_q, 2'b00};
        if (mem.MEM_ACK && (k_q == 2'd3)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      valid  <= '0;
      k_q    <= 2'd0;
      base_q <= '0;
    end else begin
      state <= state_nxt;
      if (start_fill) begin
        base_q <= PC[63:4];
        k_q    <= 2'd0;
      end else if (fill_ack) begin
        k_q <= k_q + 2'd1;
        if (k_q == 2'd3) valid[fill_idx] <= 1'b1;
      end
    end
  end

  // Storage arrays carry no reset; valid bits alone qualify their contents.
  always_ff @(posedge CLK) begin
    if (!RESET && fill_ack) begin
      data_q[fill_idx][k_q] <= mem.MEM_RDATA;
      if (k_q == 2'd3) tag_q[fill_idx] <= base_q[59:4];
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      HIT_CNT  <= 32'd0;
      MISS_CNT <= 32'd0;
    end else begin
      if (icache_r && (HIT_CNT != 32'hFFFF_FFFF))    HIT_CNT  <= HIT_CNT + 32'd1;
      if (start_fill && (MISS_CNT != 32'hFFFF_FFFF)) MISS_CNT <= MISS_CNT + 32'd1;
    end
  end
`else
  assign HIT_CNT  = 32'd0;
  assign MISS_CNT = 32'd0;
`endif

endmodule

// File: doc/imem_cache.md
IMEM_CACHE -- requirements
Module: imem_cache

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named CLK and RESET.
REQ-002 CLK  input  1  rising-edge clock.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 PC  input  64  fetch address from the fetch stage; bits [1:0] are ignored.
REQ-005 icache_r  output  1  combinational hit/ready; instruction is valid this cycle.
REQ-006 instruction  output  32  combinational instruction word for PC; 0 when icache_r=0.
REQ-007 MEM_REQ  output  1  line-fill word request to backing memory.
REQ-008 MEM_ADDR  output  64  word-aligned fill address; held stable while MEM_REQ=1 and MEM_ACK=0.
REQ-009 MEM_ACK  input  1  memory accepted the request; MEM_RDATA is valid this cycle.
REQ-010 MEM_RDATA  input  32  fill data, sampled only when MEM_REQ=1 and MEM_ACK=1.
REQ-011 HIT_CNT  output  32  count of hit cycles.
REQ-012 MISS_CNT  output  32  count of fills started.

Function
REQ-013 Geometry SHALL be direct-mapped: 16 lines of 4 words (16 B each), with tag=PC[63:8], index=PC[7:4] and word=PC[5:2]→PC[3:2].
REQ-014 Range SHALL be in_range = (PC[63:32]==0); an out-of-range PC gives icache_r=0 and instruction=0, and never starts a fill.
REQ-015 Hit SHALL be state==IDLE & in_range & valid[index] & tag[index]==PC[63:8], evaluated combinationally with zero-cycle latency.
REQ-016 The FSM SHALL have two states, IDLE and FILL.
REQ-017 IDLE→FILL SHALL occur on an in-range miss: latch the line base {PC[63:4],4'b0} and set the word counter k=0.
REQ-018 In FILL, MEM_REQ=1 and MEM_ADDR=line_base+4k; on MEM_ACK, data[index][k]<=MEM_RDATA and k<=k+1.
REQ-019 On MEM_ACK with k=3, the block SHALL set valid[index], write the tag, and return to IDLE; the earliest hit is the following cycle, so minimum miss penalty = 4 ack cycles + 1.
REQ-020 During FILL, icache_r=0, and a PC change SHALL NOT abort the fill; the latched line completes, then the current PC is looked up.
REQ-021 In IDLE, MEM_REQ=0 and MEM_ADDR=0.
REQ-022 A fill SHALL overwrite the line at the same index unconditionally; the old line is lost, with no write-back.
REQ-023 A MEM_ACK received while in IDLE SHALL be ignored.

Reset
REQ-024 RESET SHALL clear all valid bits, force IDLE, and set k=0, MEM_REQ=0, HIT_CNT=0 and MISS_CNT=0; data and tag arrays are not cleared.
REQ-025 RESET mid-FILL SHALL abandon the fill: no line is marked valid, and MEM_REQ=0 from the next cycle.
REQ-026 While RESET=1, icache_r=0 and instruction=0.

Configuration
REQ-027 The macro ICACHE_PERF_CNT_EN SHALL control the counters.
- Defined: HIT_CNT increments on each cycle with icache_r=1; MISS_CNT increments on each IDLE→FILL transition; both saturate at 32'hFFFFFFFF.
- Undefined: counter logic is absent, and HIT_CNT and MISS_CNT are tied to 0.

Verification
REQ-028 Cold miss: reset, then PC=0x0, memory acks each request after 2 cycles returning 0x00000013+k.
- MEM_ADDR sequence 0x0, 0x4, 0x8, 0xC.
- icache_r=1 the cycle after the 4th ack, with instruction=0x00000013.
REQ-029 Line hits: after REQ-028, PC=0x4, then 0x8, then 0xC.
- icache_r=1 on each cycle, instructions 0x14, 0x15, 0x16, with no MEM_REQ.
REQ-030 Conflict eviction: fill 0x0, then PC=0x100 (same index 0).
- Fill occurs at 0x100..0x10C.
- Returning to PC=0x0 causes a new miss.
REQ-031 Out of range: PC=0x0000_0001_0000_0000 → icache_r=0, instruction=0, MEM_REQ stays 0 for 10 cycles.
REQ-032 Reset mid-fill: assert RESET after the 2nd ack of a 0x40 fill.
- MEM_REQ=0 the next cycle.
- A subsequent PC=0x40 misses and refetches from 0x40.
REQ-033 PC change mid-fill and counters: switch PC 0x20→0x80 during the 0x20 fill.
- The 0x20 fill completes, then the 0x80 fill starts.
- With ICACHE_PERF_CNT_EN defined, MISS_CNT=2; without it, both counters read 0.
